// File: rtl/if_id_prefetch_queue.sv
// IF/ID prefetch FIFO: buffers fetched {PC+4, instr} words while decode holds; flush drops all.
// Optional zero-latency cut-through when empty is enabled by defining PREFETCH_BYPASS_EN.
module if_id_prefetch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq_valid,
  input  logic [DATA_W-1:0] enq_data,
  output logic              enq_ready,
  output logic              deq_valid,
  output logic [DATA_W-1:0] deq_data,
  input  logic              deq_ready,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_bypass;
  logic w_enq_fire;
  logic w_deq_fire;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

`ifdef PREFETCH_BYPASS_EN
  // Word handed straight to decode; it never occupies a slot.
  assign w_bypass = w_empty & enq_valid & deq_ready & ~flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_enq_fire = enq_valid & ~w_full & ~flush & ~w_bypass;
  assign w_deq_fire = ~w_empty & deq_ready & ~flush;

  assign enq_ready = ~w_full;
  assign count     = r_count;

  always_comb begin
    deq_valid = ~w_empty;
    deq_data  = '0;
    if (!w_empty) begin
      deq_data = r_mem[r_rd_ptr];
    end
`ifdef PREFETCH_BYPASS_EN
    else if (enq_valid && !flush) begin
      deq_valid = 1'b1;
      deq_data  = enq_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_enq_fire) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_deq_fire) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_enq_fire, w_deq_fire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; reads are masked by deq_valid.
  always_ff @(posedge clk) begin
    if (!rst && w_enq_fire) begin
      r_mem[r_wr_ptr] <= enq_data;
    end
  end

endmodule

// File: tb/tb_if_id_prefetch_queue.sv
// Self-checking bench for if_id_prefetch_queue against a queue-based reference model.
module tb_if_id_prefetch_queue;

`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid;
  logic [63:0] enq_data;
  logic        enq_ready;
  logic        deq_valid;
  logic [63:0] deq_data;
  logic        deq_ready;
  logic        flush;
  logic [2:0]  count;

  int checks = 0;
  int fails  = 0;

  logic [63:0] q[$];

  if_id_prefetch_queue #(
    .DEPTH  (4),
    .DATA_W (64),
    .CNT_W  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enq_valid (enq_valid),
    .enq_data  (enq_data),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_data  (deq_data),
    .deq_ready (deq_ready),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Reference: FIFO of words; occupancy is simply the queue size.
  function automatic int unsigned exp_count();
    return q.size();
  endfunction

  function automatic logic exp_enq_ready();
    return q.size() != DEPTH;
  endfunction

  function automatic logic exp_deq_valid();
    return (q.size() != 0) || (BYP && enq_valid && !flush);
  endfunction

  function automatic logic [63:0] exp_deq_data();
    if (q.size() != 0) return q[0];
    if (BYP && enq_valid && !flush) return enq_data;
    return 64'h0;
  endfunction

  task automatic drive(input logic r, input logic ev, input logic [63:0] ed, input logic dr,
                       input logic fl);
    rst = r; enq_valid = ev; enq_data = ed; deq_ready = dr; flush = fl;
    #1;
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    int  sz;
    bit  byp, e, d;
    sz  = q.size();
    byp = BYP && sz == 0 && enq_valid && deq_ready && !flush;
    e   = enq_valid && sz < DEPTH && !byp;
    d   = sz > 0 && deq_ready;
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
    end else begin
      if (d) void'(q.pop_front());
      if (e) q.push_back(enq_data);
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 64'h0, 0, 0);
    tick();
    drive(0, 0, 64'h0, 0, 0);
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (deq_valid !== 1'b0) begin fails++; $display("FAIL reset_deq_valid: got %b want 0", deq_valid); end
    checks++; if (deq_data !== 64'h0) begin fails++; $display("FAIL reset_deq_data: got %h want 0", deq_data); end
    checks++; if (enq_ready !== 1'b1) begin fails++; $display("FAIL reset_enq_ready: got %b want 1", enq_ready); end
  endtask

  task automatic test_two_enq();
    drive(0, 1, 64'h00000004_8C010000, 0, 0); tick();
    drive(0, 1, 64'h00000008_AC020004, 0, 0); tick();
    drive(0, 0, 64'h0, 0, 0);
    checks++; if (count !== 3'd2) begin fails++; $display("FAIL two_enq_count: got %0d want 2", count); end
    checks++; if (deq_data !== 64'h00000004_8C010000) begin
      fails++; $display("FAIL two_enq_head: got %h want 000000048c010000", deq_data); end
    checks++; if (enq_ready !== 1'b1) begin fails++; $display("FAIL two_enq_ready: got %b want 1", enq_ready); end
  endtask

  task automatic test_full();
    drive(1, 0, 64'h0, 0, 0); tick();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 64'h100 + 64'(i), 0, 0); tick();
    end
    drive(0, 1, 64'hDEAD, 0, 0);
    checks++; if (enq_ready !== 1'b0) begin fails++; $display("FAIL full_enq_ready: got %b want 0", enq_ready); end
    tick();
    checks++; if (count !== 3'd4) begin fails++; $display("FAIL full_hold_count: got %0d want 4", count); end
    // Dequeue while full: no slot opens this cycle even though decode consumes.
    drive(0, 1, 64'hBEEF, 1, 0);
    checks++; if (enq_ready !== 1'b0) begin fails++; $display("FAIL full_deq_enq_ready: got %b want 0", enq_ready); end
    tick();
    drive(0, 0, 64'h0, 0, 0);
    checks++; if (count !== 3'd3) begin fails++; $display("FAIL full_after_deq_count: got %0d want 3", count); end
    checks++; if (enq_ready !== 1'b1) begin fails++; $display("FAIL full_after_deq_ready: got %b want 1", enq_ready); end
    checks++; if (deq_data !== 64'h101) begin fails++; $display("FAIL full_after_deq_head: got %h want 101", deq_data); end
    // Drain and confirm the fifth word was never stored.
    for (int i = 1; i < DEPTH; i++) begin
      drive(0, 0, 64'h0, 1, 0);
      checks++; if (deq_data !== 64'h100 + 64'(i)) begin
        fails++; $display("FAIL full_drain_%0d: got %h want %h", i, deq_data, 64'h100 + 64'(i)); end
      tick();
    end
    drive(0, 0, 64'h0, 0, 0);
    checks++; if (deq_valid !== 1'b0) begin fails++; $display("FAIL full_drained_valid: got %b want 0", deq_valid); end
  endtask

  task automatic test_wrap();
    drive(1, 0, 64'h0, 0, 0); tick();
    drive(0, 1, 64'hA0, 0, 0); tick();
    drive(0, 1, 64'hA1, 0, 0); tick();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, {$urandom, $urandom}, 1, 0);
      checks++; if (deq_data !== exp_deq_data()) begin
        fails++; $display("FAIL wrap_data_%0d: got %h want %h", i, deq_data, exp_deq_data()); end
      tick();
      checks++; if (count !== 3'd2) begin fails++; $display("FAIL wrap_count_%0d: got %0d want 2", i, count); end
    end
  endtask

  task automatic test_flush();
    drive(1, 0, 64'h0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 64'h200 + 64'(i), 0, 0); tick();
    end
    drive(0, 1, 64'hF1F1, 1, 1); tick();
    drive(0, 0, 64'h0, 0, 0);
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL flush_count: got %0d want 0", count); end
    checks++; if (deq_valid !== 1'b0) begin fails++; $display("FAIL flush_deq_valid: got %b want 0", deq_valid); end
    checks++; if (deq_data !== 64'h0) begin fails++; $display("FAIL flush_deq_data: got %h want 0", deq_data); end
    checks++; if (enq_ready !== 1'b1) begin fails++; $display("FAIL flush_enq_ready: got %b want 1", enq_ready); end
    drive(0, 1, 64'h300, 0, 0); tick();
    drive(0, 0, 64'h0, 0, 0);
    checks++; if (deq_data !== 64'h300) begin fails++; $display("FAIL flush_next_head: got %h want 300", deq_data); end
    checks++; if (count !== 3'd1) begin fails++; $display("FAIL flush_next_count: got %0d want 1", count); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 64'h400 + 64'(i), 0, 0); tick();
    end
    drive(1, 1, 64'h4FF, 1, 0); tick();
    drive(0, 0, 64'h0, 0, 0);
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL rst_mid_count: got %0d want 0", count); end
    checks++; if (deq_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_deq_valid: got %b want 0", deq_valid); end
    checks++; if (enq_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_enq_ready: got %b want 1", enq_ready); end
  endtask

  task automatic test_bypass();
    logic       want_v;
    logic [2:0] want_c;
`ifdef PREFETCH_BYPASS_EN
    want_v = 1'b1; want_c = 3'd0;
`else
    want_v = 1'b0; want_c = 3'd1;
`endif
    drive(1, 0, 64'h0, 0, 0); tick();
    drive(0, 1, 64'h0000000C_00000000, 1, 0);
    checks++; if (deq_valid !== want_v) begin
      fails++; $display("FAIL bypass_valid: got %b want %b", deq_valid, want_v); end
    checks++; if (deq_data !== (want_v ? 64'h0000000C_00000000 : 64'h0)) begin
      fails++; $display("FAIL bypass_data: got %h", deq_data); end
    tick();
    drive(0, 0, 64'h0, 0, 0);
    checks++; if (count !== want_c) begin fails++; $display("FAIL bypass_count: got %0d want %0d", count, want_c); end
  endtask

  task automatic test_random();
    drive(1, 0, 64'h0, 0, 0); tick();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, {$urandom, $urandom},
            $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
      checks++; if (count !== 3'(exp_count())) begin
        fails++; $display("FAIL rand_count_%0d: got %0d want %0d", i, count, exp_count()); end
      checks++; if (enq_ready !== exp_enq_ready()) begin
        fails++; $display("FAIL rand_enq_ready_%0d: got %b want %b", i, enq_ready, exp_enq_ready()); end
      checks++; if (deq_valid !== exp_deq_valid()) begin
        fails++; $display("FAIL rand_deq_valid_%0d: got %b want %b", i, deq_valid, exp_deq_valid()); end
      checks++; if (deq_data !== exp_deq_data()) begin
        fails++; $display("FAIL rand_deq_data_%0d: got %h want %h", i, deq_data, exp_deq_data()); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; enq_valid = 1'b0; enq_data = '0; deq_ready = 1'b0; flush = 1'b0;
    test_reset();
    test_two_enq();
    test_full();
    test_wrap();
    test_flush();
    test_reset_midstream();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
